// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read, write, issue and flush signals plus the busy scoreboard view.
// Parameters must match those of the regfile_mp instance the bundle is connected to.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);
    localparam int NREG = 1 << AW;

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [NREG-1:0]     busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard; x0 reads as zero.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int NREG = 1 << AW;

    logic [XLEN-1:0]     mem_r [1:NREG-1];
    logic [NREG-1:0]     busy_r;
    logic [NREG-1:0]     busy_nxt_s;
    logic [NREG-1:1]     wr_hit_s;
    logic [NRD*XLEN-1:0] rd_data_s;
    logic [NRD-1:0]      rd_busy_s;

    // Per-register flag: some write port targets this register in the current cycle
    always_comb begin
        wr_hit_s = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                wr_hit_s[r] = wr_hit_s[r] |
                              (bus.wr_en[j] & (bus.wr_addr[j*AW +: AW] == AW'(r)));
            end
        end
    end

    // Scoreboard next state: flush first, then issue (new producer), then writeback
    always_comb begin
        busy_nxt_s    = busy_r;
        busy_nxt_s[0] = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (bus.flush) begin
                busy_nxt_s[r] = 1'b0;
            end else if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (wr_hit_s[r]) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
    end

    // Register storage; later ports in the loop win on an address conflict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) begin
                mem_r[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                for (int j = 0; j < NWR; j++) begin
                    if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == AW'(r))) begin
                        mem_r[r] <= bus.wr_data[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Combinational read ports; address 0 matches no stored register and yields zero
    always_comb begin
        logic [AW-1:0] ra;
        logic          byp_hit;
        ra        = '0;
        byp_hit   = 1'b0;
        rd_data_s = '0;
        rd_busy_s = '0;
        if (rst) begin
            rd_data_s = '0;
            rd_busy_s = '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                ra      = bus.rd_addr[k*AW +: AW];
                byp_hit = 1'b0;
                for (int r = 1; r < NREG; r++) begin
                    rd_data_s[k*XLEN +: XLEN] = rd_data_s[k*XLEN +: XLEN] |
                                                ({XLEN{ra == AW'(r)}} & mem_r[r]);
                    rd_busy_s[k] = rd_busy_s[k] | ((ra == AW'(r)) & busy_r[r]);
                end
`ifdef REGFILE_BYPASS_EN
                // Forward in-flight write data; highest-index port is evaluated last and wins
                for (int j = 0; j < NWR; j++) begin
                    if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == ra) && (ra != AW'(0))) begin
                        rd_data_s[k*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
                        byp_hit = 1'b1;
                    end else begin
                        rd_data_s[k*XLEN +: XLEN] = rd_data_s[k*XLEN +: XLEN];
                    end
                end
                if (byp_hit && !(bus.iss_en && (bus.iss_addr == ra))) begin
                    rd_busy_s[k] = 1'b0;
                end else begin
                    rd_busy_s[k] = rd_busy_s[k];
                end
`else
                byp_hit = 1'b0;
`endif
            end
        end
    end

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.busy_vec = rst ? {NREG{1'b0}} : {busy_r[NREG-1:1], 1'b0};
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32-bit 2R/1W instance and a 64-bit 4R/2W instance.
// Expected read-port values follow the REGFILE_BYPASS_EN setting of the build.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          dut;
        int          kind;
        int          port;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(1)) ia ();
    regfile_mp_if #(.XLEN(64), .AW(4), .NRD(4), .NWR(2)) ib ();

    regfile_mp #(.XLEN(32), .AW(5), .NRD(2), .NWR(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    regfile_mp #(.XLEN(64), .AW(4), .NRD(4), .NWR(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    // kind 0 = rd_data[port], 1 = rd_busy[port], 2 = busy_vec
    function automatic logic [63:0] fetch(input int dut, input int kind, input int port);
        logic [63:0] v;
        v = 64'h0;
        if (dut == 0) begin
            case (kind)
                0:       v = {32'h0, ia.rd_data[port*32 +: 32]};
                1:       v = {63'h0, ia.rd_busy[port]};
                default: v = {32'h0, ia.busy_vec};
            endcase
        end else begin
            case (kind)
                0:       v = ib.rd_data[port*64 +: 64];
                1:       v = {63'h0, ib.rd_busy[port]};
                default: v = {48'h0, ib.busy_vec};
            endcase
        end
        return v;
    endfunction

    // Monitor: outputs are presented every cycle; compare all queued expectations mid-cycle
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            exp_t        e;
            logic [63:0] act;
            e   = exp_q.pop_front();
            act = fetch(e.dut, e.kind, e.port);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input int d, input int k, input int p, input logic [63:0] v, input string nm);
        exp_q.push_back('{d, k, p, v, nm});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ia.wr_en  = 1'b0;
        ia.iss_en = 1'b0;
        ia.flush  = 1'b0;
    endtask

    initial begin
        ia.rd_addr = '0; ia.wr_en = '0; ia.wr_addr = '0; ia.wr_data = '0;
        ia.iss_en = 1'b0; ia.iss_addr = '0; ia.flush = 1'b0;
        ib.rd_addr = '0; ib.wr_en = '0; ib.wr_addr = '0; ib.wr_data = '0;
        ib.iss_en = 1'b0; ib.iss_addr = '0; ib.flush = 1'b0;

        step();
        chk(0, 0, 0, 64'h0, "rst_a_data0");
        chk(0, 2, 0, 64'h0, "rst_a_bvec");
        chk(1, 0, 3, 64'h0, "rst_b_data3");
        chk(1, 2, 0, 64'h0, "rst_b_bvec");
        step();
        rst = 1'b0;

        // Reset test: write+issue x5, then asynchronous reset between edges
        step();
        ia.wr_en = 1'b1; ia.wr_addr = 5'd5; ia.wr_data = 32'hDEADBEEF;
        ia.iss_en = 1'b1; ia.iss_addr = 5'd5; ia.rd_addr = {5'd0, 5'd5};
        chk(0, 0, 0, BYP ? 64'hDEADBEEF : 64'h0, "x5_wr_same_cycle");
        step();
        idle_a();
        chk(0, 0, 0, 64'hDEADBEEF, "x5_after_wr");
        chk(0, 1, 0, 64'h1, "x5_busy");
        chk(0, 2, 0, 64'h20, "bvec_x5");
        step();
        rst = 1'b1;
        chk(0, 0, 0, 64'h0, "x5_in_rst");
        chk(0, 1, 0, 64'h0, "x5_busy_in_rst");
        chk(0, 2, 0, 64'h0, "bvec_in_rst");
        @(negedge clk);
        #2;
        rst = 1'b0;
        step();
        ia.wr_en = 1'b1; ia.wr_addr = 5'd5; ia.wr_data = 32'h11111111;
        chk(0, 0, 0, BYP ? 64'h11111111 : 64'h0, "x5_post_rst_same");
        step();
        idle_a();
        chk(0, 0, 0, 64'h11111111, "x5_post_rst_wr");
        chk(0, 2, 0, 64'h0, "bvec_post_rst");

        // x0: writes and issues ignored
        step();
        ia.wr_en = 1'b1; ia.wr_addr = 5'd0; ia.wr_data = 32'h12345678;
        ia.iss_en = 1'b1; ia.iss_addr = 5'd0; ia.rd_addr = {5'd0, 5'd0};
        chk(0, 0, 0, 64'h0, "x0_same_p0");
        chk(0, 0, 1, 64'h0, "x0_same_p1");
        chk(0, 1, 0, 64'h0, "x0_busy");
        chk(0, 2, 0, 64'h0, "x0_bvec");
        step();
        idle_a();
        chk(0, 0, 1, 64'h0, "x0_after");
        chk(0, 2, 0, 64'h0, "x0_bvec_after");

        // Write-to-read visibility on x7
        step();
        ia.wr_en = 1'b1; ia.wr_addr = 5'd7; ia.wr_data = 32'h0BADF00D; ia.rd_addr = {5'd0, 5'd7};
        chk(0, 0, 0, BYP ? 64'h0BADF00D : 64'h0, "x7_first");
        step();
        ia.wr_data = 32'hA5A5A5A5;
        chk(0, 0, 0, BYP ? 64'hA5A5A5A5 : 64'h0BADF00D, "x7_bypass");
        step();
        idle_a();
        chk(0, 0, 0, 64'hA5A5A5A5, "x7_after");
        chk(0, 2, 0, 64'h0, "wb_nonbusy");

        // Scoreboard on x9
        step();
        ia.iss_en = 1'b1; ia.iss_addr = 5'd9; ia.rd_addr = {5'd9, 5'd0};
        chk(0, 1, 1, 64'h0, "x9_busy_pre");
        chk(0, 2, 0, 64'h0, "x9_bvec_pre");
        step();
        ia.wr_en = 1'b1; ia.wr_addr = 5'd9; ia.wr_data = 32'h99;
        chk(0, 2, 0, 64'h200, "x9_bvec_issued");
        chk(0, 1, 1, 64'h1, "x9_busy_iss_wb");
        chk(0, 0, 1, BYP ? 64'h99 : 64'h0, "x9_data_iss_wb");
        step();
        ia.iss_en = 1'b0; ia.wr_data = 32'h9A;
        chk(0, 2, 0, 64'h200, "set_beats_clear");
        chk(0, 1, 1, BYP ? 64'h0 : 64'h1, "x9_busy_wb");
        chk(0, 0, 1, BYP ? 64'h9A : 64'h99, "x9_data_wb");
        step();
        idle_a();
        chk(0, 2, 0, 64'h0, "x9_cleared");
        chk(0, 1, 1, 64'h0, "x9_busy_cleared");
        chk(0, 0, 1, 64'h9A, "x9_data_final");

        // Flush beats issue, and clears pending bits
        step();
        ia.iss_en = 1'b1; ia.iss_addr = 5'd4; ia.flush = 1'b1; ia.rd_addr = {5'd0, 5'd4};
        chk(0, 2, 0, 64'h0, "flush_iss_pre");
        step();
        idle_a();
        chk(0, 2, 0, 64'h0, "flush_beats_iss");
        chk(0, 1, 0, 64'h0, "x4_busy");
        step();
        ia.iss_en = 1'b1; ia.iss_addr = 5'd10;
        step();
        ia.iss_addr = 5'd11;
        chk(0, 2, 0, 64'h400, "bvec_x10");
        step();
        ia.iss_en = 1'b0; ia.flush = 1'b1;
        chk(0, 2, 0, 64'hC00, "bvec_x10_x11");
        step();
        idle_a();
        chk(0, 2, 0, 64'h0, "flush_clears");

        // Dual write conflict on the wide instance
        step();
        ib.wr_en = 2'b11; ib.wr_addr = {4'd3, 4'd3}; ib.wr_data = {64'h2, 64'h1};
        ib.rd_addr = {4'd0, 4'd0, 4'd0, 4'd3};
        chk(1, 0, 0, BYP ? 64'h2 : 64'h0, "dual_wr_same");
        step();
        ib.wr_en = 2'b00;
        chk(1, 0, 0, 64'h2, "dual_wr_conflict");

        // Four simultaneous reads of distinct registers
        step();
        ib.wr_en = 2'b11; ib.wr_addr = {4'd1, 4'd15}; ib.wr_data = {64'h1, 64'hFFFF_FFFF_FFFF_FFFF};
        step();
        ib.wr_addr = {4'd14, 4'd2}; ib.wr_data = {64'h8000_0000_0000_0000, 64'h0123_4567_89AB_CDEF};
        step();
        ib.wr_en = 2'b00; ib.rd_addr = {4'd14, 4'd2, 4'd1, 4'd15};
        chk(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, "b_x15");
        chk(1, 0, 1, 64'h1, "b_x1");
        chk(1, 0, 2, 64'h0123_4567_89AB_CDEF, "b_x2");
        chk(1, 0, 3, 64'h8000_0000_0000_0000, "b_x14");
        chk(1, 2, 0, 64'h0, "b_bvec");
        ib.iss_en = 1'b1; ib.iss_addr = 4'd15;
        step();
        ib.iss_en = 1'b0;
        chk(1, 1, 0, 64'h1, "b_busy_x15");
        chk(1, 1, 1, 64'h0, "b_busy_x1");
        chk(1, 2, 0, 64'h8000, "b_bvec_x15");

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
